duty_selector: RTL and testbench
================================

# duty_selector

Pushbutton front end for the PWM output stage. It synchronises and debounces two raw buttons, `btn_up` and `btn_down`, and keeps a registered 2-bit `duty_sel`. That output drives the duty-select input of the PWM main module directly. Each debounced press steps `duty_sel` up or down, either saturating or wrapping, and raises a one-cycle `sel_changed` strobe.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive synchronised cycles an input must hold a new level before it is accepted. 10 ms at 50 MHz. Legal range is ≥ 1.
- `WRAP`, default 0:
  - 0 saturates `duty_sel` at 0 and 3.
  - 1 wraps 3→0 and 0→3.

Ports:
- `clk`, input, 1: system clock. All state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low. `reset`=0 immediately forces every register to its reset value.
- `btn_up`, input, 1: raw button, asynchronous to `clk`, active-high, may bounce.
- `btn_down`, input, 1: raw button, same properties as `btn_up`.
- `duty_sel`, output, 2: registered duty selection. 00 selects the lowest duty, 11 the highest.
- `sel_changed`, output, 1: one-cycle pulse on the edge where `duty_sel` takes a new value.

## Operation
- **Synchroniser:** two flip-flops per button, reset to 0. The second stage is the synchronised level `s`.
- **Debouncer:** one per button. It holds a stable level `lvl` (reset 0) and a counter `cnt` (reset 0, width $clog2(DEBOUNCE_CYCLES+1)).
  - If `s`==`lvl`: `cnt` ← 0.
  - If `s`!=`lvl` and `cnt`==DEBOUNCE_CYCLES-1: `lvl` ← `s` and `cnt` ← 0.
  - If `s`!=`lvl` otherwise: `cnt` ← `cnt`+1.
  - Any return of `s` to `lvl` before acceptance restarts the count. Glitches shorter than DEBOUNCE_CYCLES are fully rejected.
- **Press event:** `press` = `lvl` & ~`lvl_d`, where `lvl_d` is `lvl` delayed one cycle (reset 0). It is exactly one cycle long per accepted 0→1 transition. Releases and holds generate nothing; there is no auto-repeat.
- **Selector FSM** (duty register plus event decode), evaluated every edge:
  - `up_press` only:
    - `duty_sel`<3: `duty_sel`+1.
    - `duty_sel`==3: wraps to 0 if WRAP=1, otherwise stays 3.
  - `down_press` only:
    - `duty_sel`>0: `duty_sel`-1.
    - `duty_sel`==0: wraps to 3 if WRAP=1, otherwise stays 0.
  - Both presses on the same edge: no change and no strobe.
  - No press: hold.
- `sel_changed` is 1 only when the new `duty_sel` differs from the old one. A saturated press gives `sel_changed`=0.
- **Reset values:** `duty_sel`=2'b00, `sel_changed`=0, all synchroniser, `lvl`, `lvl_d` and `cnt` registers 0.
- **Reset mid-operation:** a debounce in progress is discarded. A button held through reset release is seen as a fresh press after the full debounce latency.

## Timing
- Let edge E0 be the first edge sampling the raw input high. The input stays clean from then on.
  - E1: `s`=1.
  - E(1+DEBOUNCE_CYCLES): `lvl`=1.
  - E(2+DEBOUNCE_CYCLES): `duty_sel` updates and `sel_changed`=1 for that one cycle.
  - Total press latency is DEBOUNCE_CYCLES+2 cycles.
- Release is accepted DEBOUNCE_CYCLES+1 cycles after the first edge sampling low. Only then can a new press be accepted.
- `duty_sel` is glitch-free and changes only on `clk` edges, so the downstream stage may sample it directly.

## Structure
- Shared package holds:
  - `DUTY_W` = 2.
  - `DUTY_MIN` = 2'b00 and `DUTY_MAX` = 2'b11.
  - Default debounce count constant.
- Sub-module `button_debounce`: synchroniser, counter, `lvl`, `lvl_d`, `press` output, parameter DEBOUNCE_CYCLES. It is instantiated twice.
- Top `duty_selector`: the two debouncer instances plus the selector register and strobe logic.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=4 and WRAP=0 unless stated.
1. Hold `reset`=0, then release; keep both buttons 0 for 20 cycles. Required: `duty_sel`=00 and `sel_changed`=0 throughout.
2. Set `btn_up`=1 clean at E0. Required: `duty_sel` 00→01 with `sel_changed`=1 exactly at E6 and 0 at E7. Holding the button yields no further change.
3. Apply three `btn_up` pulses 3 cycles wide, each separated by 3 low cycles. Required: `duty_sel` stays 00 and no strobe. Then apply a clean 10-cycle press. Required: `duty_sel`=01.
4. Perform four clean up presses. Required: `duty_sel` goes 01, 10, 11, 11, and the fourth press has `sel_changed`=0. Repeat with WRAP=1. Required: the fourth press gives 00 with `sel_changed`=1.
5. From `duty_sel`=10, assert `btn_up` and `btn_down` clean on the same edge. Required: no change and no strobe. Separately, a down press from 00 with WRAP=0 stays 00.
6. Start `btn_up` and pulse `reset`=0 for 1 cycle at E3, while `btn_up` remains high. Required: all outputs 00/0 asynchronously. `duty_sel` becomes 01 at 6 edges after the first edge following reset release.

Source files
------------

// File: rtl/duty_selector_pkg.sv
// Shared constants, press-event encoding and the duty stepping rule
// used by the pushbutton duty selector.
package duty_selector_pkg;

  localparam int DUTY_W = 2;
  localparam logic [DUTY_W-1:0] DUTY_MIN = 2'b00;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 2'b11;

  // 10 ms at 50 MHz
  localparam int DEBOUNCE_DEFAULT = 500000;

  // Encoding is {down_press, up_press} so the event can be cast directly.
  typedef enum logic [1:0] {
    EV_NONE = 2'b00,
    EV_UP   = 2'b01,
    EV_DOWN = 2'b10,
    EV_BOTH = 2'b11
  } press_ev_e;

  // Next duty for a given press event; simultaneous presses cancel out.
  function automatic logic [DUTY_W-1:0] next_duty(
    input logic [DUTY_W-1:0] cur,
    input press_ev_e         ev,
    input logic              wrap
  );
    logic [DUTY_W-1:0] nxt;
    nxt = cur;
    case (ev)
      EV_UP: begin
        if (cur != DUTY_MAX) nxt = cur + DUTY_W'(1);
        else if (wrap)       nxt = DUTY_MIN;
      end
      EV_DOWN: begin
        if (cur != DUTY_MIN) nxt = cur - DUTY_W'(1);
        else if (wrap)       nxt = DUTY_MAX;
      end
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/duty_selector_button_debounce.sv
// Two-flop synchroniser, hold-time debouncer and rising-edge press
// detector for a single raw pushbutton.
module button_debounce
  import duty_selector_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             lvl_q, lvl_d;
  logic             lvl_prev_q, lvl_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s;

  assign s     = sync_q[1];
  assign press = lvl_q & ~lvl_prev_q;

  // Accept a new level only after it has been seen for DEBOUNCE_CYCLES
  // consecutive synchronised cycles; any return to the old level restarts.
  always_comb begin
    sync_d     = {sync_q[0], btn};
    lvl_d      = lvl_q;
    cnt_d      = cnt_q;
    lvl_prev_d = lvl_q;
    if (s == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      lvl_d = s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchroniser, debounce and edge-detect registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '0;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync_q     <= sync_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_prev_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: rtl/duty_selector.sv
// Pushbutton front end for the PWM stage: debounced up/down presses step
// a registered duty selection, with a one-cycle strobe on every change.
module duty_selector
  import duty_selector_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int WRAP            = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_up,
  input  logic              btn_down,
  output logic [DUTY_W-1:0] duty_sel,
  output logic              sel_changed
);

  logic              up_press, down_press;
  press_ev_e         ev;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              changed_q, changed_d;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_up),
    .press (up_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_down),
    .press (down_press)
  );

  // Decode the press pair and step the selection; strobe only on a real change.
  always_comb begin
    ev        = press_ev_e'({down_press, up_press});
    duty_d    = next_duty(duty_q, ev, WRAP != 0);
    changed_d = (duty_d != duty_q);
  end

  // Selection register and change strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_q    <= DUTY_MIN;
      changed_q <= 1'b0;
    end else begin
      duty_q    <= duty_d;
      changed_q <= changed_d;
    end
  end

  assign duty_sel    = duty_q;
  assign sel_changed = changed_q;

endmodule

// File: tb/tb_duty_selector.sv
// Scoreboard bench for duty_selector: a saturating and a wrapping instance
// share the same buttons; a behavioural model predicts each change.
module tb_duty_selector;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up, btn_down;
  logic [1:0] duty_sat, duty_wrap;
  logic       chg_sat, chg_wrap;

  always #5 clk = ~clk;

  duty_selector #(.DEBOUNCE_CYCLES(D), .WRAP(0)) u_sat (
    .clk         (clk),
    .reset       (reset),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .duty_sel    (duty_sat),
    .sel_changed (chg_sat)
  );

  duty_selector #(.DEBOUNCE_CYCLES(D), .WRAP(1)) u_wrap (
    .clk         (clk),
    .reset       (reset),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .duty_sel    (duty_wrap),
    .sel_changed (chg_wrap)
  );

  typedef struct {
    int cyc;
    int duty;
  } exp_t;

  exp_t q_sat[$];
  exp_t q_wrap[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state: last raw sample, synchronised sample, accepted level,
  // length of the current run disagreeing with it, pending press.
  int m_raw[2];
  int m_s[2];
  int m_lvl[2];
  int m_run[2];
  int m_press[2];
  int m_duty[2];
  int raw_now[2];
  int nd;

  function automatic int ref_step(int d, int up, int dn, int wrap);
    int v;
    v = d;
    if (up != 0 && dn == 0) v = d + 1;
    else if (dn != 0 && up == 0) v = d - 1;
    if (v > 3) v = (wrap != 0) ? 0 : 3;
    if (v < 0) v = (wrap != 0) ? 3 : 0;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // Reference model: a level is accepted once D consecutive synchronised
  // samples disagree with it; an accepted rise moves duty on the next edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        m_raw[b] = 0; m_s[b] = 0; m_lvl[b] = 0; m_run[b] = 0;
        m_press[b] = 0; m_duty[b] = 0;
      end
    end else begin
      cyc++;
      for (int w = 0; w < 2; w++) begin
        nd = ref_step(m_duty[w], m_press[0], m_press[1], w);
        if (nd != m_duty[w]) begin
          if (w == 0) q_sat.push_back('{cyc, nd});
          else        q_wrap.push_back('{cyc, nd});
        end
        m_duty[w] = nd;
      end
      raw_now[0] = int'(btn_up);
      raw_now[1] = int'(btn_down);
      for (int b = 0; b < 2; b++) begin
        m_press[b] = 0;
        if (m_s[b] != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == D) begin
            m_lvl[b]   = m_s[b];
            m_run[b]   = 0;
            m_press[b] = m_lvl[b];
          end
        end else begin
          m_run[b] = 0;
        end
        m_s[b]   = m_raw[b];
        m_raw[b] = raw_now[b];
      end
    end
  end

  // Monitor: compare levels every cycle, pop an expectation on each strobe.
  always @(negedge clk) begin
    exp_t e;
    int   want;
    check("sat_duty", int'(duty_sat), m_duty[0]);
    check("wrap_duty", int'(duty_wrap), m_duty[1]);
    want = (q_sat.size() > 0 && q_sat[0].cyc == cyc) ? 1 : 0;
    check("sat_strobe", int'(chg_sat), want);
    if (want != 0) begin
      e = q_sat.pop_front();
      check("sat_new_duty", int'(duty_sat), e.duty);
    end
    want = (q_wrap.size() > 0 && q_wrap[0].cyc == cyc) ? 1 : 0;
    check("wrap_strobe", int'(chg_wrap), want);
    if (want != 0) begin
      e = q_wrap.pop_front();
      check("wrap_new_duty", int'(duty_wrap), e.duty);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
  endtask

  task automatic press_btn(input logic up, input logic dn);
    btn_up   = up;
    btn_down = dn;
    tick(10);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick(10);
  endtask

  initial begin
    reset    = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick(3);
    reset = 1'b1;

    // idle after reset
    tick(20);

    // single clean press, then held
    btn_up = 1'b1;
    tick(14);
    btn_up = 1'b0;
    tick(10);

    // short glitches rejected, then a real press
    for (int k = 0; k < 3; k++) begin
      btn_up = 1'b1; tick(3);
      btn_up = 1'b0; tick(3);
    end
    btn_up = 1'b1; tick(10);
    btn_up = 1'b0; tick(10);

    // four up presses: saturate vs wrap
    pulse_reset();
    for (int k = 0; k < 4; k++) press_btn(1'b1, 1'b0);

    // both together, then downs past zero
    pulse_reset();
    press_btn(1'b1, 1'b0);
    press_btn(1'b1, 1'b0);
    press_btn(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) press_btn(1'b0, 1'b1);

    // reset mid-debounce with button held high
    btn_up = 1'b1;
    tick(3);
    reset = 1'b0;
    #1;
    check("async_rst_wrap_duty", int'(duty_wrap), 0);
    check("async_rst_sat_strobe", int'(chg_sat), 0);
    tick(1);
    reset = 1'b1;
    tick(12);
    btn_up = 1'b0;
    tick(10);

    // randomized bouncing on both buttons
    for (int k = 0; k < 120; k++) begin
      case ($urandom_range(0, 3))
        0: btn_up   = ~btn_up;
        1: btn_down = ~btn_down;
        2: begin btn_up = ~btn_up; btn_down = ~btn_down; end
        default: ;
      endcase
      tick($urandom_range(1, 12));
      if ($urandom_range(0, 49) == 0) pulse_reset();
    end

    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick(20);
    check("sat_queue_drained", q_sat.size(), 0);
    check("wrap_queue_drained", q_wrap.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
